// File: rtl/ser_pkg.sv
// Shared types and defaults for the serial transmitter arbiter.
package ser_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 64;
  localparam int GID_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_BUSY = 2'd2,
    ST_ACK  = 2'd3
  } arb_state_e;

  // Next requester index after idx, wrapping to 0 at n.
  function automatic logic [GID_W-1:0] wrap_inc(input logic [GID_W-1:0] idx, input int n);
    return (int'(idx) == n - 1) ? '0 : idx + GID_W'(1);
  endfunction

endpackage

// File: rtl/ser_rr_arb.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping modulo N_REQ.
module ser_rr_arb
  import ser_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GID_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [GID_W-1:0] gnt_idx
);

  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [N_REQ-1:0] hit;
  logic [GID_W-1:0] cand [N_REQ];

  // Candidate gi is the requester gi positions after the pointer.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [GID_W:0] sum;
    assign sum      = {1'b0, ptr} + (GID_W+1)'(gi);
    assign cand[gi] = (sum >= (GID_W+1)'(N_REQ)) ? GID_W'(sum - (GID_W+1)'(N_REQ))
                                                  : sum[GID_W-1:0];
    assign hit[gi]  = |(req & (ONE_HOT0 << cand[gi]));
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (hit[i]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[i];
      end
    end
  end

endmodule

// File: rtl/serial_arbiter.sv
// Round-robin sharing of one serializer between N_REQ requesters.
// Optional watchdog enabled by defining SER_ARB_TIMEOUT_EN.
module serial_arbiter
  import ser_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    sclk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic                    busy,
  output logic [GID_W-1:0]        grant_id,
  output logic                    load_data,
  output logic [DATA_W-1:0]       data_out,
  input  logic                    data_enable,
  input  logic                    tran_done,
  output logic                    timeout_err
);

  arb_state_e        state_q, state_d;
  logic [GID_W-1:0]  ptr_q, ptr_d;
  logic [GID_W-1:0]  gid_q, gid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              gnt_valid;
  logic [GID_W-1:0]  gnt_idx;
  logic              expire;

  ser_rr_arb #(.N_REQ(N_REQ)) u_rr (
    .req       (req),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        // A serializer still finishing an aborted word blocks new grants.
        if (gnt_valid && !data_enable && !tran_done) begin
          gid_d   = gnt_idx;
          data_d  = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (expire) begin
          ptr_d   = wrap_inc(gid_q, N_REQ);
          state_d = ST_IDLE;
        end else if (data_enable) begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (expire) begin
          ptr_d   = wrap_inc(gid_q, N_REQ);
          state_d = ST_IDLE;
        end else if (tran_done) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        ptr_d   = wrap_inc(gid_q, N_REQ);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ack
    assign ack[gi] = (state_q == ST_ACK) && (gid_q == GID_W'(gi));
  end

  assign busy      = (state_q != ST_IDLE);
  assign load_data = (state_q == ST_LOAD);
  assign grant_id  = gid_q;
  assign data_out  = data_q;

`ifdef SER_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Counts every cycle spent in LOAD or BUSY; fires on the TIMEOUT-th one.
  always_comb begin
    cnt_d  = '0;
    err_d  = err_q;
    expire = 1'b0;
    if (state_q == ST_LOAD || state_q == ST_BUSY) begin
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        expire = 1'b1;
        err_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  // No watchdog: the FSM waits on the serializer indefinitely.
  assign expire      = 1'b0;
  assign timeout_err = (TIMEOUT < 0);
`endif

endmodule
